// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between fetch_unit (master)
// and the instruction cache or memory (slave).
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: issues predictor PCs to instruction memory, tracks in-flight requests
// and squashes stale responses after a flush. Optional counters: FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  npc,
    input  logic         flush,
    output logic         fetch_stall,
    fetch_unit_if.master imem,
    output logic [31:0]  inst_feedback,
    output logic         inst_valid,
    output logic [31:0]  inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_stall_cycles,
    output logic [31:0]  perf_dropped
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      addr_q [DEPTH];

    logic fire;
    logic pop;
    logic live;

    // Issue gating uses the registered count, so a pop frees a slot only next cycle.
    always_comb begin
        imem.imem_req_valid = !rst && !flush && (outstanding < CNT_W'(DEPTH));
        imem.imem_req_addr  = npc;
        fire                = imem.imem_req_valid && imem.imem_req_ready;
        fetch_stall         = !fire;
        pop                 = imem.imem_resp_valid && (outstanding != '0);
        live                = pop && (drop_cnt == '0) && !flush;
        inst_valid          = live;
        inst_feedback       = live ? imem.imem_resp_data : NOP_WORD;
        inst_pc             = addr_q[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (fire)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({fire, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            // A flush replaces the drop count with everything still in flight.
            if (flush)
                drop_cnt <= outstanding - CNT_W'(pop);
            else if (pop && (drop_cnt != '0))
                drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fire)
            addr_q[wr_ptr] <= npc;
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_dropped      <= '0;
        end else begin
            if (fetch_stall)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (pop && !live)
                perf_dropped <= perf_dropped + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    // A response with nothing in flight means the memory was not reset with us.
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(imem.imem_resp_valid && (outstanding == '0)));
    end
`endif

endmodule
